add_round_key_seq: RTL and testbench
====================================

ADD_ROUND_KEY_SEQ -- requirements
Module: add_round_key_seq

Interface
REQ-001 Parameter STATE_W, 128, width of the AES state and round key in bits.
REQ-002 Parameter WORD_W, 32, bits XORed per cycle; SHALL divide STATE_W exactly; NWORDS = STATE_W/WORD_W.
REQ-003 Parameter NUM_ROUNDS, 11, number of round-key additions per block; round counter range is 0..NUM_ROUNDS-1.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 Clear  input  1  synchronous abort; returns the block to IDLE and zeroes the round counter.
REQ-007 in_valid  input  1  state and key on in_state/in_key are valid.
REQ-008 in_ready  output  1  block can accept an operation.
REQ-009 in_state  input  STATE_W  state to be keyed.
REQ-010 in_key  input  STATE_W  round key for this operation.
REQ-011 out_valid  output  1  out_state holds a completed result.
REQ-012 out_ready  input  1  consumer accepts out_state.
REQ-013 out_state  output  STATE_W  in_state XOR in_key.
REQ-014 round_idx  output  $clog2(NUM_ROUNDS)  index of the round the current or held result belongs to.
REQ-015 last_round  output  1  high while round_idx == NUM_ROUNDS-1.

Function
REQ-016 FSM states IDLE, RUN, DONE; in_ready SHALL be high only in IDLE.
REQ-017 IDLE: in_valid high captures in_state and in_key into internal registers, clears word counter, moves to RUN.
REQ-018 RUN: each cycle XOR word k (bits k*WORD_W+WORD_W-1 : k*WORD_W) of captured state with the same slice of captured key and write it in place; k starts at 0 (LSB word) and increments by 1.
REQ-019 RUN: after word NWORDS-1 is written, word counter wraps to 0 and FSM moves to DONE.
REQ-020 Latency: handshake accepted in cycle 0, out_valid rises in cycle NWORDS+1 and result equals the full-width XOR.
REQ-021 DONE: out_valid high, out_state stable; when out_ready is high, FSM returns to IDLE and round_idx increments next cycle.
REQ-022 round_idx wraps from NUM_ROUNDS-1 to 0 on the completing transfer.
REQ-023 in_ready is low in DONE even if out_ready is high; one IDLE cycle always separates operations.
REQ-024 out_state SHALL be exactly the captured register contents; changes on in_state/in_key after capture have no effect.
REQ-025 Clear SHALL take priority over in_valid and out_ready in the same cycle; a result in progress or held in DONE is discarded, with no round_idx increment.
REQ-026 WORD_W == STATE_W SHALL work: RUN lasts one cycle.

Reset
REQ-027 Reset_n low SHALL immediately force IDLE, word counter 0, round_idx 0, out_valid 0, out_state 0, in_ready 1 after release.
REQ-028 Reset asserted mid-RUN or in DONE SHALL discard the operation; first accept after release starts at round 0.

Configuration
REQ-029 Macro ADD_ROUND_KEY_PARITY_EN: when defined, adds output out_parity (1 bit), registered with out_state, equal to the XOR-reduction of out_state and valid when out_valid is high; reset value 0.
REQ-030 Without ADD_ROUND_KEY_PARITY_EN, out_parity port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Defaults, in_state=0x00112233445566778899AABBCCDDEEFF, in_key=0x000102030405060708090A0B0C0D0E0F, out_ready=1 -> out_valid in cycle 5 with out_state 0x00102030405060708090A0B0C0D0E0F0, round_idx 0->1.
REQ-032 Eleven back-to-back operations -> round_idx 0..10, last_round high only on the 11th, round_idx 0 afterwards.
REQ-033 out_ready held low 20 cycles in DONE -> out_valid and out_state stable, in_ready low, round_idx unchanged.
REQ-034 Clear asserted in cycle 2 of RUN together with in_valid -> IDLE next cycle, no out_valid, round_idx 0, new operation not captured.
REQ-035 Reset_n pulsed low in DONE -> out_valid 0 and out_state 0 immediately, round_idx 0.
REQ-036 WORD_W=128 and WORD_W=8 builds with random vectors, with ADD_ROUND_KEY_PARITY_EN defined -> latency 2 and 17, out_state and out_parity match reference XOR model.

Source files
------------

// File: rtl/add_round_key_seq.sv
// add_round_key_seq: word-serial AES AddRoundKey.
// Captures a state/key pair, XORs one WORD_W slice per cycle in place
// (LSB word first), then holds the result until the consumer takes it.
// A round index tracks which of the NUM_ROUNDS key additions the result
// belongs to.
// Optional feature: define ADD_ROUND_KEY_PARITY_EN to add out_parity_o,
// the XOR-reduction of out_state_o, registered alongside it.
module add_round_key_seq #(
  parameter int STATE_W    = 128,
  parameter int WORD_W     = 32,
  parameter int NUM_ROUNDS = 11,
  localparam int IDX_W     = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [STATE_W-1:0] in_state_i,
  input  logic [STATE_W-1:0] in_key_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [STATE_W-1:0] out_state_o,
`ifdef ADD_ROUND_KEY_PARITY_EN
  output logic               out_parity_o,
`endif
  output logic [IDX_W-1:0]   round_idx_o,
  output logic               last_round_o
);

  localparam int NWORDS = STATE_W / WORD_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [STATE_W-1:0] data_q, data_d;
  logic [STATE_W-1:0] key_q, key_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [IDX_W-1:0]   round_q, round_d;
  logic               last_word;

  assign last_word = (word_cnt_q == CNT_W'(NWORDS - 1));

  // FSM state register.
  // NOTE: clocked blocks use non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: clear overrides every handshake.
  // NOTE: each combinational output gets a default first so no path leaves
  // it unassigned; a missing default infers a latch.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (in_valid_i)  state_d = RUN;
        RUN:     if (last_word)   state_d = DONE;
        DONE:    if (out_ready_i) state_d = IDLE;
        default:                  state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: ready only in IDLE, valid only in DONE.
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
  end

  // Datapath next state: capture, word-serial XOR, round advance on transfer.
  always_comb begin
    data_d     = data_q;
    key_d      = key_q;
    word_cnt_d = word_cnt_q;
    round_d    = round_q;
    if (clear_i) begin
      word_cnt_d = '0;
      round_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            data_d     = in_state_i;
            key_d      = in_key_i;
            word_cnt_d = '0;
          end
        end
        RUN: begin
          for (int k = 0; k < NWORDS; k++) begin
            if (word_cnt_q == CNT_W'(k)) begin
              data_d[k*WORD_W +: WORD_W] = data_q[k*WORD_W +: WORD_W] ^ key_q[k*WORD_W +: WORD_W];
            end
          end
          word_cnt_d = last_word ? '0 : word_cnt_q + CNT_W'(1);
        end
        DONE: begin
          if (out_ready_i) begin
            round_d = (round_q == IDX_W'(NUM_ROUNDS - 1)) ? '0 : round_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  // NOTE: the state and key registers are reset on purpose: out_state must
  // read zero straight out of reset, so they cannot be left as plain RAM-like
  // storage without reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      key_q      <= '0;
      word_cnt_q <= '0;
      round_q    <= '0;
    end else begin
      data_q     <= data_d;
      key_q      <= key_d;
      word_cnt_q <= word_cnt_d;
      round_q    <= round_d;
    end
  end

  assign out_state_o  = data_q;
  assign round_idx_o  = round_q;
  assign last_round_o = (round_q == IDX_W'(NUM_ROUNDS - 1));

`ifdef ADD_ROUND_KEY_PARITY_EN
  logic parity_q;

  // Parity tracks the state register so it is valid whenever out_state is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= ^data_d;
  end

  assign out_parity_o = parity_q;
`endif

endmodule

// File: tb/tb_add_round_key_seq.sv
// Testbench for add_round_key_seq. Three instances share data inputs:
// the default WORD_W=32 build plus WORD_W=128 and WORD_W=8 builds.
// Define ADD_ROUND_KEY_PARITY_EN for both RTL and bench to check out_parity.
module tb_add_round_key_seq;

  localparam int NUM_ROUNDS = 11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         in_valid;
  logic         in_valid_x;
  logic         out_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;

  logic         in_ready,  in_ready_a,  in_ready_b;
  logic         out_valid, out_valid_a, out_valid_b;
  logic [127:0] out_state, out_state_a, out_state_b;
  logic [3:0]   round_idx, round_idx_a, round_idx_b;
  logic         last_round, last_round_a, last_round_b;
`ifdef ADD_ROUND_KEY_PARITY_EN
  logic         out_parity, out_parity_a, out_parity_b;
`endif

  int checks = 0;
  int errors = 0;
  int model_round   = 0;  // main instance
  int model_round_x = 0;  // WORD_W=128 and WORD_W=8 instances

  always #5 clk = ~clk;

  add_round_key_seq #(.STATE_W(128), .WORD_W(32), .NUM_ROUNDS(NUM_ROUNDS)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_state_i(in_state), .in_key_i(in_key),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_state_o(out_state),
`ifdef ADD_ROUND_KEY_PARITY_EN
    .out_parity_o(out_parity),
`endif
    .round_idx_o(round_idx), .last_round_o(last_round)
  );

  add_round_key_seq #(.STATE_W(128), .WORD_W(128), .NUM_ROUNDS(NUM_ROUNDS)) u_w128 (
    .clk(clk), .rst_n(rst_n), .clear_i(clear),
    .in_valid_i(in_valid_x), .in_ready_o(in_ready_a),
    .in_state_i(in_state), .in_key_i(in_key),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready), .out_state_o(out_state_a),
`ifdef ADD_ROUND_KEY_PARITY_EN
    .out_parity_o(out_parity_a),
`endif
    .round_idx_o(round_idx_a), .last_round_o(last_round_a)
  );

  add_round_key_seq #(.STATE_W(128), .WORD_W(8), .NUM_ROUNDS(NUM_ROUNDS)) u_w8 (
    .clk(clk), .rst_n(rst_n), .clear_i(clear),
    .in_valid_i(in_valid_x), .in_ready_o(in_ready_b),
    .in_state_i(in_state), .in_key_i(in_key),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready), .out_state_o(out_state_b),
`ifdef ADD_ROUND_KEY_PARITY_EN
    .out_parity_o(out_parity_b),
`endif
    .round_idx_o(round_idx_b), .last_round_o(last_round_b)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One operation on the main instance; hold = cycles out_ready stays low in DONE.
  task automatic do_op(input logic [127:0] st, input logic [127:0] key, input int hold);
    logic [127:0] exp;
    int c;
    exp = st ^ key;
    check("op_in_ready", 128'(in_ready), 128'(1));
    in_state  = st;
    in_key    = key;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    step();
    in_valid = 1'b0;
    in_state = rand128();
    in_key   = rand128();
    c = 1;
    while (!out_valid && c < 40) begin
      step();
      c++;
    end
    check("op_latency", 128'(c), 128'(5));
    check("op_state", out_state, exp);
    check("op_round", 128'(round_idx), 128'(model_round));
    check("op_last", 128'(last_round), 128'(model_round == NUM_ROUNDS - 1));
    check("op_done_not_ready", 128'(in_ready), 128'(0));
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", 128'(out_valid), 128'(1));
      check("hold_state", out_state, exp);
      check("hold_in_ready", 128'(in_ready), 128'(0));
      check("hold_round", 128'(round_idx), 128'(model_round));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    model_round = (model_round + 1) % NUM_ROUNDS;
    check("xfer_valid", 128'(out_valid), 128'(0));
    check("xfer_in_ready", 128'(in_ready), 128'(1));
    check("xfer_round", 128'(round_idx), 128'(model_round));
  endtask

  // One operation on all three instances; latency = STATE_W/WORD_W + 1.
  task automatic multi_op();
    logic [127:0] st, key, exp;
    int lat0, lat1, lat2;
    st  = rand128();
    key = rand128();
    exp = st ^ key;
    lat0 = -1; lat1 = -1; lat2 = -1;
    in_state   = st;
    in_key     = key;
    in_valid   = 1'b1;
    in_valid_x = 1'b1;
    out_ready  = 1'b0;
    step();
    in_valid   = 1'b0;
    in_valid_x = 1'b0;
    in_state   = rand128();
    in_key     = rand128();
    for (int c = 1; c < 40; c++) begin
      if (out_valid   && lat0 < 0) lat0 = c;
      if (out_valid_a && lat1 < 0) lat1 = c;
      if (out_valid_b && lat2 < 0) lat2 = c;
      if (lat0 >= 0 && lat1 >= 0 && lat2 >= 0) break;
      step();
    end
    check("lat_w32", 128'(lat0), 128'(5));
    check("lat_w128", 128'(lat1), 128'(2));
    check("lat_w8", 128'(lat2), 128'(17));
    check("state_w32", out_state, exp);
    check("state_w128", out_state_a, exp);
    check("state_w8", out_state_b, exp);
    check("round_w32", 128'(round_idx), 128'(model_round));
    check("round_w128", 128'(round_idx_a), 128'(model_round_x));
    check("round_w8", 128'(round_idx_b), 128'(model_round_x));
    check("last_w128", 128'(last_round_a), 128'(model_round_x == NUM_ROUNDS - 1));
    check("last_w8", 128'(last_round_b), 128'(model_round_x == NUM_ROUNDS - 1));
`ifdef ADD_ROUND_KEY_PARITY_EN
    check("par_w32", 128'(out_parity), 128'(^exp));
    check("par_w128", 128'(out_parity_a), 128'(^exp));
    check("par_w8", 128'(out_parity_b), 128'(^exp));
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    model_round   = (model_round + 1) % NUM_ROUNDS;
    model_round_x = (model_round_x + 1) % NUM_ROUNDS;
    check("x_in_ready_w128", 128'(in_ready_a), 128'(1));
    check("x_in_ready_w8", 128'(in_ready_b), 128'(1));
  endtask

  initial begin
    int c;
    rst_n      = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    in_valid_x = 1'b0;
    out_ready  = 1'b0;
    in_state   = '0;
    in_key     = '0;

    // Reset state.
    repeat (3) step();
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_state", out_state, 128'(0));
    check("rst_round", 128'(round_idx), 128'(0));
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_last", 128'(last_round), 128'(0));

    // Reference vector.
    do_op(128'h00112233445566778899AABBCCDDEEFF, 128'h000102030405060708090A0B0C0D0E0F, 0);
    check("ref_round_after", 128'(round_idx), 128'(1));

    // Clear zeroes the round counter, then eleven back-to-back operations.
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_round   = 0;
    model_round_x = 0;
    check("clear_round", 128'(round_idx), 128'(0));
    for (int i = 0; i < NUM_ROUNDS; i++) do_op(rand128(), rand128(), 0);
    check("wrap_round", 128'(round_idx), 128'(0));
    check("wrap_last", 128'(last_round), 128'(0));

    // Consumer stalls 20 cycles in DONE.
    do_op(rand128(), rand128(), 20);

    // Clear in RUN cycle 2 together with a new in_valid.
    in_state  = rand128();
    in_key    = rand128();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    clear    = 1'b1;
    in_valid = 1'b1;
    in_state = rand128();
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    model_round = 0;
    check("clr_run_in_ready", 128'(in_ready), 128'(1));
    check("clr_run_valid", 128'(out_valid), 128'(0));
    check("clr_run_round", 128'(round_idx), 128'(0));
    for (int i = 0; i < 8; i++) begin
      step();
      check("clr_run_idle_valid", 128'(out_valid), 128'(0));
      check("clr_run_idle_ready", 128'(in_ready), 128'(1));
    end
    out_ready = 1'b0;

    // Clear in DONE with out_ready high discards the result.
    do_op(rand128(), rand128(), 0);
    in_state = rand128();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    c = 1;
    while (!out_valid && c < 40) begin
      step();
      c++;
    end
    check("clr_done_reached", 128'(out_valid), 128'(1));
    clear     = 1'b1;
    out_ready = 1'b1;
    step();
    clear     = 1'b0;
    out_ready = 1'b0;
    model_round = 0;
    check("clr_done_valid", 128'(out_valid), 128'(0));
    check("clr_done_round", 128'(round_idx), 128'(0));

    // Asynchronous reset while holding a result in DONE.
    do_op(rand128(), rand128(), 0);
    in_state = rand128();
    in_key   = rand128();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    c = 1;
    while (!out_valid && c < 40) begin
      step();
      c++;
    end
    check("rstd_reached", 128'(out_valid), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rstd_valid", 128'(out_valid), 128'(0));
    check("rstd_state", out_state, 128'(0));
    check("rstd_round", 128'(round_idx), 128'(0));
    step();
    rst_n = 1'b1;
    model_round   = 0;
    model_round_x = 0;
    step();

    // Asynchronous reset mid-RUN, then a fresh operation starts at round 0.
    in_state = rand128();
    in_key   = rand128();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("rstr_state", out_state, 128'(0));
    step();
    rst_n = 1'b1;
    step();
    do_op(rand128(), rand128(), 0);

    // Random operations across the three word widths and random stalls.
    for (int i = 0; i < 8; i++) multi_op();
    for (int i = 0; i < 6; i++) do_op(rand128(), rand128(), int'($urandom_range(0, 3)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
